// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial pattern detector.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock on
// ser_out with a data strobe (ser_valid), an end-of-word pulse (frame_done)
// and an optional fixed idle gap after every word.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam int                 GAP_W    = 4;
  // Gap counter counts down from GAP_CYCLES-1 to 0, one GAP cycle per value.
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  shreg_r;   // current bit always sits at the head position
  logic [CNT_W-1:0]  cnt_r;     // bits remaining after the one on ser_out
  logic [GAP_W-1:0]  gap_r;

  logic              last_bit_s;
  logic              take_s;
  logic [WIDTH-1:0]  shifted_s;

  // Bit that leaves first for a given word image.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Word image after the head bit has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  assign last_bit_s = (cnt_r == CNT_ZERO);
  assign shifted_s  = advance(shreg_r);
  assign take_s     = din_valid & din_ready;

  // Ready is combinational so a word can be chained into the last-bit cycle.
  always_comb begin
    din_ready = 1'b0;
    if (rst) begin
      din_ready = 1'b0;
    end else if (state_r == ST_IDLE) begin
      din_ready = 1'b1;
    end else if ((state_r == ST_SHIFT) && last_bit_s && (GAP_CYCLES == 0)) begin
      din_ready = 1'b1;
    end else begin
      din_ready = 1'b0;
    end
  end

  // Control FSM with registered serial outputs; reset abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      cnt_r      <= CNT_ZERO;
      gap_r      <= {GAP_W{1'b0}};
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            shreg_r    <= din;
            cnt_r      <= CNT_LAST;
            ser_out    <= head_bit(din);
            ser_valid  <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (!last_bit_s) begin
            shreg_r    <= shifted_s;
            cnt_r      <= cnt_r - CNT_ONE;
            ser_out    <= head_bit(shifted_s);
            ser_valid  <= 1'b1;
            frame_done <= (cnt_r == CNT_ONE);
            busy       <= 1'b1;
          end else if (take_s) begin
            // Chained word: first bit follows the previous last bit directly.
            shreg_r    <= din;
            cnt_r      <= CNT_LAST;
            ser_out    <= head_bit(din);
            ser_valid  <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b1;
          end else if (GAP_CYCLES == 0) begin
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            gap_r      <= GAP_LOAD;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
            state_r    <= ST_GAP;
          end
        end

        ST_GAP: begin
          ser_out    <= IDLE_LEVEL;
          ser_valid  <= 1'b0;
          frame_done <= 1'b0;
          if (gap_r == {GAP_W{1'b0}}) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_r   <= gap_r - 4'd1;
            busy    <= 1'b1;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= CNT_ZERO;
          ser_out    <= IDLE_LEVEL;
          ser_valid  <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: three instances cover MSB-first
// without gap, LSB-first, and a 2-cycle inter-word gap. Expected serial bits
// are pushed to a scoreboard queue when a word is driven and popped as the
// DUT emits valid bits.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] din_a = 8'h00, din_l = 8'h00, din_g = 8'h00;
  logic dv_a = 1'b0, dv_l = 1'b0, dv_g = 1'b0;
  logic rdy_a, rdy_l, rdy_g;
  logic so_a, so_l, so_g;
  logic sv_a, sv_l, sv_g;
  logic fd_a, fd_l, fd_g;
  logic bz_a, bz_l, bz_g;

  int tests  = 0;
  int failed = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .frame_done(fd_a), .busy(bz_a));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
    .ser_out(so_l), .ser_valid(sv_l), .frame_done(fd_l), .busy(bz_l));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut_g (
    .clk(clk), .rst(rst), .din(din_g), .din_valid(dv_g), .din_ready(rdy_g),
    .ser_out(so_g), .ser_valid(sv_g), .frame_done(fd_g), .busy(bz_g));

  // Push the serial order of a word onto the scoreboard.
  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(msb ? w[7-j] : w[j]);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    tests++; if ({so_a, sv_a, fd_a, bz_a, rdy_a} !== 5'b10000) begin failed++; $display("FAIL reset_a got %b want 10000", {so_a, sv_a, fd_a, bz_a, rdy_a}); end
    tests++; if ({so_l, sv_l, fd_l, bz_l, rdy_l} !== 5'b10000) begin failed++; $display("FAIL reset_l got %b want 10000", {so_l, sv_l, fd_l, bz_l, rdy_l}); end
    tests++; if ({so_g, sv_g, fd_g, bz_g, rdy_g} !== 5'b10000) begin failed++; $display("FAIL reset_g got %b want 10000", {so_g, sv_g, fd_g, bz_g, rdy_g}); end
    rst = 1'b0;
    #1;
    tests++; if ({rdy_a, rdy_l, rdy_g} !== 3'b111) begin failed++; $display("FAIL reset_release_ready got %b want 111", {rdy_a, rdy_l, rdy_g}); end
  endtask

  task automatic test_single();
    logic e;
    @(negedge clk);
    din_a = 8'hA5; dv_a = 1'b1; push_word(8'hA5, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin dv_a = 1'b0; din_a = 8'h00; end
      if (c <= 8) begin
        tests++;
        if (sv_a !== 1'b1 || exp_q.size() == 0) begin failed++; $display("FAIL single_valid cyc %0d got %b want 1", c, sv_a); end
        else begin
          e = exp_q.pop_front();
          tests++; if (so_a !== e) begin failed++; $display("FAIL single_bit cyc %0d got %b want %b", c, so_a, e); end
        end
        tests++; if (fd_a !== (c == 8)) begin failed++; $display("FAIL single_frame_done cyc %0d got %b want %b", c, fd_a, (c == 8)); end
        tests++; if (bz_a !== 1'b1) begin failed++; $display("FAIL single_busy cyc %0d got %b want 1", c, bz_a); end
      end else begin
        tests++; if ({so_a, sv_a, fd_a, bz_a} !== 4'b1000) begin failed++; $display("FAIL single_idle got %b want 1000", {so_a, sv_a, fd_a, bz_a}); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    @(negedge clk);
    din_a = 8'h0F; dv_a = 1'b1; push_word(8'h0F, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) dv_a = 1'b0;
      if (c <= 8) begin
        tests++; if (rdy_a !== (c == 8)) begin failed++; $display("FAIL b2b_ready cyc %0d got %b want %b", c, rdy_a, (c == 8)); end
      end
      if (c == 8) begin din_a = 8'hF0; dv_a = 1'b1; push_word(8'hF0, 1'b1); end
      if (c == 9) begin dv_a = 1'b0; din_a = 8'h00; end
      if (c <= 16) begin
        tests++;
        if (sv_a !== 1'b1 || exp_q.size() == 0) begin failed++; $display("FAIL b2b_valid cyc %0d got %b want 1", c, sv_a); end
        else begin
          e = exp_q.pop_front();
          tests++; if (so_a !== e) begin failed++; $display("FAIL b2b_bit cyc %0d got %b want %b", c, so_a, e); end
        end
        tests++; if (fd_a !== (c == 8 || c == 16)) begin failed++; $display("FAIL b2b_frame_done cyc %0d got %b want %b", c, fd_a, (c == 8 || c == 16)); end
      end else begin
        tests++; if ({so_a, sv_a, fd_a, bz_a} !== 4'b1000) begin failed++; $display("FAIL b2b_idle got %b want 1000", {so_a, sv_a, fd_a, bz_a}); end
      end
    end
  endtask

  task automatic test_lsb_first();
    logic e;
    logic [7:0] words [2];
    words[0] = 8'h01; words[1] = 8'h80;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      din_l = words[w]; dv_l = 1'b1; push_word(words[w], 1'b0);
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c == 1) dv_l = 1'b0;
        if (c <= 8) begin
          tests++;
          if (sv_l !== 1'b1 || exp_q.size() == 0) begin failed++; $display("FAIL lsb_valid word %0d cyc %0d got %b want 1", w, c, sv_l); end
          else begin
            e = exp_q.pop_front();
            tests++; if (so_l !== e) begin failed++; $display("FAIL lsb_bit word %0d cyc %0d got %b want %b", w, c, so_l, e); end
          end
          tests++; if (fd_l !== (c == 8)) begin failed++; $display("FAIL lsb_frame_done cyc %0d got %b want %b", c, fd_l, (c == 8)); end
        end else begin
          tests++; if ({so_l, sv_l} !== 2'b10) begin failed++; $display("FAIL lsb_idle got %b want 10", {so_l, sv_l}); end
        end
      end
    end
  endtask

  task automatic test_gap();
    logic e;
    @(negedge clk);
    din_g = 8'hFF; dv_g = 1'b1; push_word(8'hFF, 1'b1);
    tests++; if (rdy_g !== 1'b1) begin failed++; $display("FAIL gap_ready0 got %b want 1", rdy_g); end
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c <= 10) begin
        tests++; if (rdy_g !== 1'b0) begin failed++; $display("FAIL gap_ready_low cyc %0d got %b want 0", c, rdy_g); end
      end
      if (c == 11) begin
        tests++; if (rdy_g !== 1'b1) begin failed++; $display("FAIL gap_ready_high cyc 11 got %b want 1", rdy_g); end
        din_g = 8'h5A; push_word(8'h5A, 1'b1);
      end
      if (c == 12) begin dv_g = 1'b0; din_g = 8'h00; end
      if ((c >= 1 && c <= 8) || (c >= 12 && c <= 19)) begin
        tests++;
        if (sv_g !== 1'b1 || exp_q.size() == 0) begin failed++; $display("FAIL gap_valid cyc %0d got %b want 1", c, sv_g); end
        else begin
          e = exp_q.pop_front();
          tests++; if (so_g !== e) begin failed++; $display("FAIL gap_bit cyc %0d got %b want %b", c, so_g, e); end
        end
        tests++; if (fd_g !== (c == 8 || c == 19)) begin failed++; $display("FAIL gap_frame_done cyc %0d got %b want %b", c, fd_g, (c == 8 || c == 19)); end
      end else if (c == 9 || c == 10 || c == 20 || c == 21) begin
        tests++; if ({so_g, sv_g, fd_g, bz_g} !== 4'b1001) begin failed++; $display("FAIL gap_idle cyc %0d got %b want 1001", c, {so_g, sv_g, fd_g, bz_g}); end
      end else if (c == 22) begin
        tests++; if ({sv_g, bz_g, rdy_g} !== 3'b001) begin failed++; $display("FAIL gap_done got %b want 001", {sv_g, bz_g, rdy_g}); end
      end
    end
    tests++; if (exp_q.size() != 0) begin failed++; $display("FAIL gap_queue_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic e;
    @(negedge clk);
    din_a = 8'hA5; dv_a = 1'b1; push_word(8'hA5, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) dv_a = 1'b0;
      if (exp_q.size() == 0) begin tests++; failed++; $display("FAIL rmf_queue_empty cyc %0d got 0 want >0", c); end
      else begin
        e = exp_q.pop_front();
        tests++; if ({sv_a, so_a} !== {1'b1, e}) begin failed++; $display("FAIL rmf_bit cyc %0d got %b want %b", c, {sv_a, so_a}, {1'b1, e}); end
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++; if ({so_a, sv_a, fd_a, bz_a, rdy_a} !== 5'b10000) begin failed++; $display("FAIL rmf_async got %b want 10000", {so_a, sv_a, fd_a, bz_a, rdy_a}); end
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if ({fd_a, sv_a} !== 2'b00) begin failed++; $display("FAIL rmf_hold got %b want 00", {fd_a, sv_a}); end
    end
    rst = 1'b0; din_a = 8'h3C; dv_a = 1'b1; push_word(8'h3C, 1'b1);
    #1;
    tests++; if (rdy_a !== 1'b1) begin failed++; $display("FAIL rmf_ready_after got %b want 1", rdy_a); end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) dv_a = 1'b0;
      if (c <= 8) begin
        tests++;
        if (sv_a !== 1'b1 || exp_q.size() == 0) begin failed++; $display("FAIL rmf_valid cyc %0d got %b want 1", c, sv_a); end
        else begin
          e = exp_q.pop_front();
          tests++; if (so_a !== e) begin failed++; $display("FAIL rmf_bit2 cyc %0d got %b want %b", c, so_a, e); end
        end
        tests++; if (fd_a !== (c == 8)) begin failed++; $display("FAIL rmf_frame_done cyc %0d got %b want %b", c, fd_a, (c == 8)); end
      end else begin
        tests++; if (sv_a !== 1'b0) begin failed++; $display("FAIL rmf_idle got %b want 0", sv_a); end
      end
    end
  endtask

  // Detector integration: a 0101 sequence detector consumes ser_out.
  task automatic test_detector();
    logic e;
    logic [3:0] hist = 4'b0000;
    int nb = 0;
    logic y;
    @(negedge clk);
    din_a = 8'b0101_0000; dv_a = 1'b1; push_word(8'b0101_0000, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) dv_a = 1'b0;
      if (sv_a === 1'b1) begin
        hist = {hist[2:0], so_a};
        nb++;
      end
      y = (nb >= 4) && (hist == 4'b0101);
      if (exp_q.size() == 0) begin tests++; failed++; $display("FAIL det_queue_empty cyc %0d got 0 want >0", c); end
      else begin
        e = exp_q.pop_front();
        tests++; if ({sv_a, so_a} !== {1'b1, e}) begin failed++; $display("FAIL det_bit cyc %0d got %b want %b", c, {sv_a, so_a}, {1'b1, e}); end
      end
      tests++; if (y !== (c == 4)) begin failed++; $display("FAIL det_y cyc %0d got %b want %b", c, y, (c == 4)); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_gap();
    test_reset_mid_frame();
    test_detector();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
